// File: rtl/mul_add_nat_pkg.sv
// Shared definitions for the natural-number multiply-add unit:
// control-state encoding and the result-width helper.
package mul_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int result_width(input int n, input int m);
    return n + m;
  endfunction

endpackage

// File: rtl/mul_add_nat_if.sv
// Request/result bundle for mul_add_nat; master drives operands, slave returns m.
interface mul_add_nat_if
  import mul_add_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 4
) ();

  logic                          start;
  logic [N-1:0]                  x;
  logic [M-1:0]                  y;
  logic [N-1:0]                  c;
  logic                          ready;
  logic                          valid;
  logic [result_width(N, M)-1:0] m;

  modport master (output start, output x, output y, output c,
                  input  ready, input  valid, input  m);

  modport slave  (input  start, input  x, input  y, input  c,
                  output ready, output valid, output m);

endinterface

// File: rtl/mul_add_nat.sv
// Iterative shift-and-add unit computing m = x*y + c, consuming one bit of y per clock.
// Results never overflow the N+M-bit accumulator, so no saturation logic exists.
module mul_add_nat
  import mul_add_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic         clock,
  input  logic         reset,
  mul_add_nat_if.slave bus
);

  localparam int W  = result_width(N, M);
  localparam int CW = $clog2(M + 1);

  state_t          state_r;
  state_t          next_state_s;
  logic            capture_s;
  logic            last_s;
  logic            ready_r;
  logic            valid_r;
  logic [W-1:0]    acc_r;
  logic [W-1:0]    mcand_r;
  logic [M-1:0]    yq_r;
  logic [CW-1:0]   cnt_r;
  logic [W-1:0]    acc_sum_s;
  logic [W-1:0]    m_r;

  assign last_s    = (cnt_r == CW'(M - 1));
  assign bus.ready = ready_r;
  assign bus.valid = valid_r;
  assign bus.m     = m_r;

  // Control FSM: next-state decode and operand-capture strobe.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          next_state_s = ST_RUN;
          capture_s    = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          next_state_s = ST_RUN;
          capture_s    = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register; ready/valid are registered from the next state so outputs stay glitch-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ready_r <= (next_state_s != ST_RUN);
      valid_r <= (next_state_s == ST_DONE);
    end
  end

  // Conditional partial-product add for the current multiplier bit.
  always_comb begin
    if (yq_r[0]) begin
      acc_sum_s = acc_r + mcand_r;
    end else begin
      acc_sum_s = acc_r;
    end
  end

  // Operand capture, shift registers and iteration counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_r   <= {W{1'b0}};
      mcand_r <= {W{1'b0}};
      yq_r    <= {M{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (capture_s) begin
      acc_r   <= {{M{1'b0}}, bus.c};
      mcand_r <= {{M{1'b0}}, bus.x};
      yq_r    <= bus.y;
      cnt_r   <= {CW{1'b0}};
    end else if (state_r == ST_RUN) begin
      acc_r   <= acc_sum_s;
      mcand_r <= mcand_r << 1;
      yq_r    <= yq_r >> 1;
      cnt_r   <= cnt_r + CW'(1);
    end
  end

  // Result register: written once per operation, on the final iteration.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_r <= {W{1'b0}};
    end else if ((state_r == ST_RUN) && last_s) begin
      m_r <= acc_sum_s;
    end
  end

endmodule

// File: tb/tb_mul_add_nat.sv
// Directed and randomized checks of mul_add_nat at N=M=4 and N=8,M=4.
module tb_mul_add_nat;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat;
  logic rdy_bad;

  always #5 clock = ~clock;

  mul_add_nat_if #(.N(4), .M(4)) a_if ();
  mul_add_nat_if #(.N(8), .M(4)) b_if ();

  mul_add_nat #(.N(4), .M(4)) u_a (.clock(clock), .reset(reset), .bus(a_if.slave));
  mul_add_nat #(.N(8), .M(4)) u_b (.clock(clock), .reset(reset), .bus(b_if.slave));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_a(input string tag, input logic [3:0] x, input logic [3:0] y,
                       input logic [3:0] c, input logic [7:0] exp);
    int   l;
    logic rb;
    @(negedge clock);
    a_if.start = 1'b1; a_if.x = x; a_if.y = y; a_if.c = c;
    @(posedge clock);
    #1;
    a_if.start = 1'b0; a_if.x = 4'd0; a_if.y = 4'd0; a_if.c = 4'd0;
    l  = 0;
    rb = 1'b0;
    do begin
      @(negedge clock);
      l++;
      if (!a_if.valid && a_if.ready) rb = 1'b1;
    end while (!a_if.valid && l < 20);
    check_eq({tag, "_lat"}, l, 5);
    check_eq({tag, "_m"}, a_if.m, exp);
    check_eq({tag, "_rdy"}, rb, 1'b0);
    @(negedge clock);
    check_eq({tag, "_pulse"}, a_if.valid, 1'b0);
  endtask

  task automatic run_b(input string tag, input logic [7:0] x, input logic [3:0] y,
                       input logic [7:0] c, input logic [11:0] exp);
    int l;
    @(negedge clock);
    b_if.start = 1'b1; b_if.x = x; b_if.y = y; b_if.c = c;
    @(posedge clock);
    #1;
    b_if.start = 1'b0; b_if.x = 8'd0; b_if.y = 4'd0; b_if.c = 8'd0;
    l = 0;
    do begin
      @(negedge clock);
      l++;
    end while (!b_if.valid && l < 20);
    check_eq({tag, "_lat"}, l, 5);
    check_eq({tag, "_m"}, b_if.m, exp);
  endtask

  logic [3:0] bb_x [3] = '{4'd3, 4'd12, 4'd1};
  logic [3:0] bb_y [3] = '{4'd5, 4'd11, 4'd15};
  logic [3:0] bb_c [3] = '{4'd1, 4'd3, 4'd0};
  logic [7:0] bb_e [3] = '{8'd16, 8'd135, 8'd15};

  initial begin
    a_if.start = 1'b0; a_if.x = 4'd0; a_if.y = 4'd0; a_if.c = 4'd0;
    b_if.start = 1'b0; b_if.x = 8'd0; b_if.y = 4'd0; b_if.c = 8'd0;

    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_ready", a_if.ready, 1'b1);
    check_eq("rst_valid", a_if.valid, 1'b0);
    check_eq("rst_m", a_if.m, 8'd0);
    reset = 1'b0;

    run_a("a_99", 4'd9, 4'd10, 4'd9, 8'd99);
    run_a("a_25", 4'd2, 4'd10, 4'd5, 8'd25);
    run_a("a_max", 4'd15, 4'd15, 4'd15, 8'd240);
    run_a("a_zero", 4'd0, 4'd0, 4'd0, 8'd0);

    // start held high: each DONE-cycle operand set is captured, RUN-time inputs ignored
    @(negedge clock);
    a_if.start = 1'b1; a_if.x = bb_x[0]; a_if.y = bb_y[0]; a_if.c = bb_c[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      a_if.x = 4'd15; a_if.y = 4'd15; a_if.c = 4'd15;
      lat     = 0;
      rdy_bad = 1'b0;
      do begin
        @(negedge clock);
        lat++;
        if (!a_if.valid && a_if.ready) rdy_bad = 1'b1;
      end while (!a_if.valid && lat < 20);
      check_eq("b2b_lat", lat, 5);
      check_eq("b2b_m", a_if.m, bb_e[i]);
      check_eq("b2b_rdy", rdy_bad, 1'b0);
      if (i < 2) begin
        a_if.x = bb_x[i+1]; a_if.y = bb_y[i+1]; a_if.c = bb_c[i+1];
      end else begin
        a_if.start = 1'b0;
      end
    end
    @(negedge clock);
    check_eq("b2b_end_valid", a_if.valid, 1'b0);

    // abort on the second RUN cycle
    @(negedge clock);
    a_if.start = 1'b1; a_if.x = 4'd7; a_if.y = 4'd7; a_if.c = 4'd1;
    @(posedge clock);
    #1;
    a_if.start = 1'b0;
    @(negedge clock);
    check_eq("abort_run_ready", a_if.ready, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("abort_ready", a_if.ready, 1'b1);
    check_eq("abort_valid", a_if.valid, 1'b0);
    check_eq("abort_m", a_if.m, 8'd0);
    reset = 1'b0;
    run_a("a_rerun", 4'd7, 4'd7, 4'd1, 8'd50);

    run_b("b_2855", 8'd200, 4'd13, 8'd255, 12'd2855);
    for (int k = 0; k < 1000; k++) begin
      int rx, ry, rc;
      rx = $urandom_range(0, 255);
      ry = $urandom_range(0, 15);
      rc = $urandom_range(0, 255);
      run_b("b_rand", 8'(rx), 4'(ry), 8'(rc), 12'(rx * ry + rc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
